// File: rtl/decimator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decimator_pkg
// Purpose  : Shared constants and helpers for the multi-channel decimator.
//            - MODE_PICK / MODE_ACC : run-time output mode encoding
//            - acc_bw()             : accumulator width for a lane
//            - sat_to_bw()          : clamp a wide signed value to a narrower
//                                     two's-complement range (used only when
//                                     DECIMATOR_SAT_EN is defined)
// Revision : 1.0 - initial release
// ============================================================================
package decimator_pkg;

  localparam logic MODE_PICK = 1'b0;
  localparam logic MODE_ACC  = 1'b1;

  // A group of up to 2^FACTOR_BW-1 samples can never carry out of this width.
  function automatic int acc_bw(input int data_bw, input int factor_bw);
    return data_bw + factor_bw;
  endfunction

  // Clamp val to [-2^(bw-1), 2^(bw-1)-1]; result stays 64-bit, caller narrows.
  function automatic logic signed [63:0] sat_to_bw(input logic signed [63:0] val,
                                                   input int                 bw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (bw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (val > hi) begin
      return hi;
    end
    if (val < lo) begin
      return lo;
    end
    return val;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decimator_if.sv
`default_nettype none
// ============================================================================
// Module   : decimator_if
// Purpose  : Sample stream bundle for decimator_mc.
// Signals  : data_i  [NUM_CH*DATA_BW] input samples, channel k at k*DATA_BW
//            valid_i                  input sample strobe (no backpressure)
//            data_o  [NUM_CH*DATA_BW] decimated samples
//            valid_o                  output valid
//            ready_i                  downstream accept
// Modports : master - stream source / sink side (drives data_i, valid_i,
//                     ready_i)
//            slave  - decimator side
// Revision : 1.0 - initial release
// ============================================================================
interface decimator_if #(
  parameter int DATA_BW = 8,
  parameter int NUM_CH  = 2
);

  logic [NUM_CH*DATA_BW-1:0] data_i;
  logic                      valid_i;
  logic [NUM_CH*DATA_BW-1:0] data_o;
  logic                      valid_o;
  logic                      ready_i;

  modport master (
    output data_i,
    output valid_i,
    output ready_i,
    input  data_o,
    input  valid_o
  );

  modport slave (
    input  data_i,
    input  valid_i,
    input  ready_i,
    output data_o,
    output valid_o
  );

endinterface
`default_nettype wire

// File: rtl/decim_acc_lane.sv
`default_nettype none
// ============================================================================
// Module   : decim_acc_lane
// Purpose  : One channel of boxcar accumulation. Keeps the running group sum,
//            and presents (sum + current sample) >>> shift, narrowed to
//            DATA_BW, as a combinational result for the top level to latch
//            on the group's last beat.
//            Narrowing: DECIMATOR_SAT_EN defined   -> saturate
//                       DECIMATOR_SAT_EN undefined -> truncate (wraps)
// Ports    : clk_i, rst_i  clock, asynchronous active-high reset
//            clr_i         synchronous clear of the accumulator
//            valid_i       sample beat
//            first_i       beat is the first of a group (cnt == 0)
//            last_i        beat is the last of a group (cnt == D-1)
//            shift_i       arithmetic right shift of the group sum
//            data_i        signed input sample
//            result_o      shifted, narrowed group result
// Revision : 1.0 - initial release
// ============================================================================
module decim_acc_lane
  import decimator_pkg::*;
#(
  parameter int DATA_BW   = 8,
  parameter int FACTOR_BW = 8,
  parameter int SHIFT_BW  = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clr_i,
  input  logic                      valid_i,
  input  logic                      first_i,
  input  logic                      last_i,
  input  logic [SHIFT_BW-1:0]       shift_i,
  input  logic signed [DATA_BW-1:0] data_i,
  output logic signed [DATA_BW-1:0] result_o
);

  localparam int ACC_BW = acc_bw(DATA_BW, FACTOR_BW);

  logic signed [ACC_BW-1:0] acc_q;
  logic signed [ACC_BW-1:0] acc_d;
  logic signed [ACC_BW-1:0] w_data_ext;
  logic signed [ACC_BW-1:0] w_sum;
  logic signed [ACC_BW-1:0] w_shifted;

  assign w_data_ext = ACC_BW'(data_i);
  // First beat restarts the sum, so a stale accumulator never leaks in.
  assign w_sum      = first_i ? w_data_ext : (acc_q + w_data_ext);
  assign w_shifted  = w_sum >>> shift_i;

`ifdef DECIMATOR_SAT_EN
  assign result_o = DATA_BW'(sat_to_bw(64'(w_shifted), DATA_BW));
`else
  assign result_o = DATA_BW'(w_shifted);
`endif

  // The closing beat's sum is consumed directly; the next beat is a first
  // beat, so the register need not capture it.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (valid_i && !last_i) begin
      acc_d = w_sum;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/decimator_mc.sv
`default_nettype none
// ============================================================================
// Module   : decimator_mc
// Purpose  : NUM_CH lock-step channel decimator with run-time factor D.
//            Pick mode outputs the first sample of each group of D valid
//            beats; accumulate mode outputs the shifted boxcar sum of the
//            group. Registered output with valid/ready handshake; results
//            that complete while the output is stalled are dropped and
//            flagged on the sticky overflow_o.
//            Optional macro DECIMATOR_SAT_EN: saturate the accumulate result
//            instead of wrapping it.
// Ports    : clk_i       clock, rising edge
//            rst_i       asynchronous active-high reset
//            en_i        0: load config shadow, clear phase/acc/valid/flag
//            decim_i     decimation factor (0 and 1 both mean 1)
//            mode_i      MODE_PICK / MODE_ACC
//            shift_i     arithmetic right shift for accumulate mode
//            bus         decimator_if.slave sample stream in/out
//            overflow_o  sticky dropped-result flag
// Revision : 1.0 - initial release
// ============================================================================
module decimator_mc
  import decimator_pkg::*;
#(
  parameter int DATA_BW   = 8,
  parameter int NUM_CH    = 2,
  parameter int FACTOR_BW = 8,
  parameter int SHIFT_BW  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [FACTOR_BW-1:0] decim_i,
  input  logic                 mode_i,
  input  logic [SHIFT_BW-1:0]  shift_i,
  decimator_if.slave           bus,
  output logic                 overflow_o
);

  // Config shadow
  logic [FACTOR_BW-1:0]      decim_q, decim_d;
  logic                      mode_q, mode_d;
  logic [SHIFT_BW-1:0]       shift_q, shift_d;
  // Phase and output state
  logic [FACTOR_BW-1:0]      cnt_q, cnt_d;
  logic                      valid_q, valid_d;
  logic                      ovf_q, ovf_d;
  logic [NUM_CH*DATA_BW-1:0] data_q, data_d;

  logic [FACTOR_BW-1:0]      w_last_cnt;
  logic                      w_beat;
  logic                      w_first;
  logic                      w_last;
  logic                      w_done;
  logic                      w_accept;
  logic [NUM_CH*DATA_BW-1:0] w_result;

  assign w_beat     = en_i & bus.valid_i;
  // decim 0 is treated as 1, so its last phase is also 0.
  assign w_last_cnt = (decim_q == '0) ? '0 : (decim_q - FACTOR_BW'(1));
  assign w_first    = (cnt_q == '0);
  assign w_last     = (cnt_q == w_last_cnt);
  assign w_done     = w_beat & ((mode_q == MODE_PICK) ? w_first : w_last);
  assign w_accept   = valid_q & bus.ready_i;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    logic signed [DATA_BW-1:0] w_lane_res;

    decim_acc_lane #(
      .DATA_BW   (DATA_BW),
      .FACTOR_BW (FACTOR_BW),
      .SHIFT_BW  (SHIFT_BW)
    ) u_lane (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (~en_i),
      .valid_i  (w_beat),
      .first_i  (w_first),
      .last_i   (w_last),
      .shift_i  (shift_q),
      .data_i   (bus.data_i[k*DATA_BW +: DATA_BW]),
      .result_o (w_lane_res)
    );

    assign w_result[k*DATA_BW +: DATA_BW] = (mode_q == MODE_PICK)
                                            ? bus.data_i[k*DATA_BW +: DATA_BW]
                                            : w_lane_res;
  end

  always_comb begin
    decim_d = decim_q;
    mode_d  = mode_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    data_d  = data_q;
    if (!en_i) begin
      decim_d = decim_i;
      mode_d  = mode_i;
      shift_d = shift_i;
      cnt_d   = '0;
      valid_d = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      if (w_beat) begin
        cnt_d = w_last ? '0 : (cnt_q + FACTOR_BW'(1));
      end
      if (w_accept) begin
        valid_d = 1'b0;
      end
      // A held, unaccepted result wins over the new one; a result that
      // lands on the accepting edge replaces it without a gap.
      if (w_done) begin
        if (valid_q && !bus.ready_i) begin
          ovf_d = 1'b1;
        end else begin
          data_d  = w_result;
          valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      decim_q <= FACTOR_BW'(1);
      mode_q  <= MODE_PICK;
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      decim_q <= decim_d;
      mode_q  <= mode_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      data_q  <= data_d;
    end
  end

  assign bus.data_o  = data_q;
  assign bus.valid_o = valid_q;
  assign overflow_o  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_decimator_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_decimator_mc
// Purpose  : Self-checking bench for decimator_mc. A behavioural model
//            groups valid beats arithmetically (beat index mod D), sums or
//            picks samples, and predicts valid_o / data_o / overflow_o each
//            cycle. Honours DECIMATOR_SAT_EN for the expected narrowing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decimator_mc;

  localparam int DATA_BW   = 8;
  localparam int NUM_CH    = 2;
  localparam int FACTOR_BW = 8;
  localparam int SHIFT_BW  = 4;
  localparam int SAT_HI    = (1 << (DATA_BW - 1)) - 1;
  localparam int SAT_LO    = -(1 << (DATA_BW - 1));
  localparam int DMASK     = (1 << DATA_BW) - 1;
`ifdef DECIMATOR_SAT_EN
  localparam int EXP_100X4 = 127;
`else
  localparam int EXP_100X4 = 144;
`endif

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic                 en_i;
  logic [FACTOR_BW-1:0] decim_i;
  logic                 mode_i;
  logic [SHIFT_BW-1:0]  shift_i;
  logic                 overflow_o;

  decimator_if #(.DATA_BW(DATA_BW), .NUM_CH(NUM_CH)) bus ();

  decimator_mc #(
    .DATA_BW   (DATA_BW),
    .NUM_CH    (NUM_CH),
    .FACTOR_BW (FACTOR_BW),
    .SHIFT_BW  (SHIFT_BW)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (en_i),
    .decim_i    (decim_i),
    .mode_i     (mode_i),
    .shift_i    (shift_i),
    .bus        (bus.slave),
    .overflow_o (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_d, m_mode, m_shift, m_n;
  int m_sum  [NUM_CH];
  int m_last [NUM_CH];
  int m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int fix(input int s);
    int v;
    v = s >>> m_shift;
`ifdef DECIMATOR_SAT_EN
    if (v > SAT_HI) v = SAT_HI;
    else if (v < SAT_LO) v = SAT_LO;
    return v;
`else
    begin
      logic [DATA_BW-1:0] t;
      t = DATA_BW'(v);
      return int'($signed(t));
    end
`endif
  endfunction

  task automatic chk_data(input string tag);
    for (int k = 0; k < NUM_CH; k++) begin
      chk($sformatf("%s data_o ch%0d", tag, k),
          32'(bus.data_o[k*DATA_BW +: DATA_BW]), m_last[k] & DMASK);
    end
  endtask

  task automatic configure(input int d, input bit mode, input int sh);
    logic [DATA_BW-1:0] r;
    en_i    = 1'b0;
    decim_i = FACTOR_BW'(d);
    mode_i  = mode;
    shift_i = SHIFT_BW'(sh);
    // valid_i during en_i=0 must be ignored
    bus.valid_i = 1'b1;
    for (int k = 0; k < NUM_CH; k++) begin
      r = DATA_BW'($urandom);
      bus.data_i[k*DATA_BW +: DATA_BW] = r;
    end
    @(posedge clk_i); #1;
    chk("en low valid_o", 32'(bus.valid_o), 0);
    chk("en low overflow_o", 32'(overflow_o), 0);
    chk_data("en low");
    en_i        = 1'b1;
    bus.valid_i = 1'b0;
    m_d     = (d == 0) ? 1 : d;
    m_mode  = mode;
    m_shift = sh;
    m_n     = 0;
    m_ovf   = 0;
  endtask

  // kind 0: random samples; 1: ch0 ramp over valid beats; 2: constants c0/c1
  task automatic run_stream(input int ncyc, input int kind, input int c0,
                            input int c1, input int gap_pct);
    int ramp;
    ramp = 0;
    for (int i = 0; i < ncyc; i++) begin
      int  samp [NUM_CH];
      bit  v;
      bit  done;
      int  pos;
      logic [DATA_BW-1:0] r;
      v = ($urandom_range(0, 99) >= gap_pct);
      for (int k = 0; k < NUM_CH; k++) begin
        if (kind == 2) r = DATA_BW'((k == 0) ? c0 : c1);
        else if (kind == 1 && k == 0) r = DATA_BW'(ramp);
        else r = DATA_BW'($urandom);
        samp[k] = int'($signed(r));
        bus.data_i[k*DATA_BW +: DATA_BW] = r;
      end
      bus.valid_i = v;
      bus.ready_i = 1'b1;
      done = 1'b0;
      if (v) begin
        pos = m_n % m_d;
        for (int k = 0; k < NUM_CH; k++) begin
          m_sum[k] = ((pos == 0) ? 0 : m_sum[k]) + samp[k];
        end
        if (m_mode == 0 && pos == 0) begin
          done = 1'b1;
          for (int k = 0; k < NUM_CH; k++) m_last[k] = samp[k];
        end
        if (m_mode == 1 && pos == m_d - 1) begin
          done = 1'b1;
          for (int k = 0; k < NUM_CH; k++) m_last[k] = fix(m_sum[k]);
        end
        m_n++;
        ramp++;
      end
      @(posedge clk_i); #1;
      chk("stream valid_o", 32'(bus.valid_o), 32'(done));
      chk_data("stream");
      chk("stream overflow_o", 32'(overflow_o), 32'(m_ovf));
    end
    bus.valid_i = 1'b0;
  endtask

  initial begin
    rst_i       = 1'b1;
    en_i        = 1'b1;
    decim_i     = FACTOR_BW'(4);
    mode_i      = 1'b1;
    shift_i     = '0;
    bus.data_i  = '0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    m_d = 1; m_mode = 0; m_shift = 0; m_n = 0; m_ovf = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      m_sum[k]  = 0;
      m_last[k] = 0;
    end

    // Reset values
    @(posedge clk_i); #1;
    chk("reset valid_o", 32'(bus.valid_o), 0);
    chk("reset overflow_o", 32'(overflow_o), 0);
    chk_data("reset");
    rst_i = 1'b0;

    // Reset config is D=1 pick: every valid beat passes straight through
    run_stream(10, 0, 0, 0, 20);

    // Pick D=4, ch0 ramp: outputs 0,4,8
    configure(4, 0, 0);
    run_stream(12, 1, 0, 0, 0);
    chk("pick ramp last ch0", 32'(bus.data_o[DATA_BW-1:0]), 8);

    // Accumulate D=4 shift=2, constants 12 / -8
    configure(4, 1, 2);
    run_stream(12, 2, 12, -8, 0);
    chk("acc const ch1", 32'(bus.data_o[DATA_BW +: DATA_BW]), 32'(-8 & DMASK));

    // Accumulate D=4 shift=0, 4*100 exceeds DATA_BW range
    configure(4, 1, 0);
    run_stream(8, 2, 100, -3, 0);
    chk("acc 4x100 ch0", 32'(bus.data_o[DATA_BW-1:0]), EXP_100X4);

    // Randomised accumulate runs, including D=0 (treated as 1) and max D
    configure(0, 1, 1);
    run_stream(20, 0, 0, 0, 25);
    configure(7, 1, 3);
    run_stream(60, 0, 0, 0, 30);
    configure(3, 0, 0);
    run_stream(30, 0, 0, 0, 30);
    configure(255, 1, 7);
    run_stream(520, 0, 0, 0, 0);

    // Backpressure, pick D=2, ready_i low for 6 beats
    configure(2, 0, 0);
    for (int i = 0; i < 6; i++) begin
      logic [DATA_BW-1:0] r;
      bus.ready_i = 1'b0;
      bus.valid_i = 1'b1;
      for (int k = 0; k < NUM_CH; k++) begin
        r = DATA_BW'($urandom);
        bus.data_i[k*DATA_BW +: DATA_BW] = r;
        if (i == 0) m_last[k] = int'($signed(r));
      end
      if (i > 0 && (i % 2) == 0) m_ovf = 1;
      @(posedge clk_i); #1;
      chk("bp valid_o", 32'(bus.valid_o), 1);
      chk_data("bp");
      chk("bp overflow_o", 32'(overflow_o), 32'(m_ovf));
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    @(posedge clk_i); #1;
    chk("bp drained valid_o", 32'(bus.valid_o), 0);
    chk("bp sticky overflow_o", 32'(overflow_o), 1);
    configure(2, 0, 0);
    run_stream(8, 0, 0, 0, 0);

    // Mid-group asynchronous reset, D=5 accumulate
    configure(5, 1, 1);
    run_stream(3, 0, 0, 0, 0);
    #3 rst_i = 1'b1;
    #1;
    for (int k = 0; k < NUM_CH; k++) m_last[k] = 0;
    chk("async rst valid_o", 32'(bus.valid_o), 0);
    chk("async rst overflow_o", 32'(overflow_o), 0);
    chk_data("async rst");
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    m_d = 1; m_mode = 0; m_shift = 0; m_n = 0; m_ovf = 0;
    run_stream(4, 0, 0, 0, 0);
    configure(5, 1, 1);
    run_stream(17, 0, 0, 0, 20);

    // Mid-group en_i drop, D=5
    configure(5, 1, 0);
    run_stream(3, 0, 0, 0, 0);
    configure(5, 1, 0);
    run_stream(20, 0, 0, 0, 10);

    // decim_i change while enabled is ignored until en_i pulses low
    configure(4, 0, 0);
    run_stream(10, 0, 0, 0, 0);
    decim_i = FACTOR_BW'(2);
    run_stream(16, 0, 0, 0, 20);
    configure(2, 0, 0);
    run_stream(12, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decimator_mc.md
# decimator_mc

Parametrised, multi-channel successor to the single-channel fixed-rate decimator in the DFE chain after the integrator-comb filter. Decimates NUM_CH lock-step channels by a factor selected at run time. Each output is either one picked sample or a scaled boxcar sum of the group. Output is registered, uses a valid/ready handshake, and reports dropped results.

## Interface
- DATA_BW, 8, width of one signed two's-complement sample
- NUM_CH, 2, number of channels packed in data_i/data_o; channel k at bits [k*DATA_BW +: DATA_BW]
- FACTOR_BW, 8, width of decim_i; maximum factor 2^FACTOR_BW-1
- SHIFT_BW, 4, width of shift_i
- clk_i  input  1  single clock, rising edge
- rst_i  input  1  asynchronous, active-high reset
- en_i  input  1  enable; low synchronously clears state and loads config
- decim_i  input  FACTOR_BW  decimation factor D; 0 and 1 both mean D=1
- mode_i  input  1  0 = pick, 1 = accumulate
- shift_i  input  SHIFT_BW  arithmetic right shift applied to the accumulate result
- data_i  input  NUM_CH*DATA_BW  input samples
- valid_i  input  1  input sample strobe; no input backpressure
- data_o  output  NUM_CH*DATA_BW  decimated samples
- valid_o  output  1  output valid
- ready_i  input  1  downstream accept
- overflow_o  output  1  sticky flag: a result was dropped

## Operation
- Config shadow: while en_i=0, decim_i, mode_i and shift_i are registered every cycle. While en_i=1 the shadow holds, and input changes are ignored.
- Phase counter cnt counts 0..D-1, advancing only on valid_i and wrapping to 0 after D-1. A group is D consecutive valid samples starting at cnt=0.
- Pick mode: the sample with cnt=0 is the result. It completes on that same valid beat, matching the legacy phase (first sample of each group).
- Accumulate mode, per channel:
  - On cnt=0: acc <= sign-extended data.
  - Otherwise: acc <= acc + data.
  - On the beat with cnt=D-1, result = (acc + data) >>> shift_i. For D=1 this is data >>> shift_i every beat.
- acc width ACC_BW = DATA_BW + FACTOR_BW. The sum never overflows.
- Narrowing ACC_BW to DATA_BW: see Configuration.
- Output register: a completed result loads data_o and sets valid_o on the next clock edge.
  - valid_o stays high until valid_o & ready_i. It then clears unless a new result loads on the same edge; the new load wins.
- Drop rule: if a result completes while valid_o=1 & ready_i=0, the new result is discarded, the old one is held, and overflow_o <= 1.
- overflow_o clears only on reset or en_i=0.
- en_i=0 synchronously clears cnt, acc, valid_o and overflow_o. data_o holds its value.
- Reset values: every output is 0. cnt, acc and valid_o are 0. The config shadow is D=1, pick mode, shift 0.

## Timing
- Latency: exactly 1 cycle from the completing valid_i beat to valid_o.
- Throughput: with D=1 and ready_i tied high, one output per input beat.
- Reset mid-group discards the partial group. After en_i rises, the first valid beat is cnt=0.
- en_i low for one cycle is enough to reload the config and restart the phase.
- valid_i while en_i=0 is ignored.

## Configuration
- DECIMATOR_SAT_EN defined: the shifted accumulate result saturates to [-2^(DATA_BW-1), 2^(DATA_BW-1)-1].
- DECIMATOR_SAT_EN undefined: the shifted result is truncated to its low DATA_BW bits, so it wraps.
- Pick mode is unaffected by the macro.

## Structure
- Package decimator_pkg holds:
  - mode constants MODE_PICK = 1'b0 and MODE_ACC = 1'b1
  - function acc_bw(DATA_BW, FACTOR_BW)
  - a saturate-to-DATA_BW function, used only under DECIMATOR_SAT_EN
- Sub-module decim_acc_lane, instantiated NUM_CH times, holds one channel's accumulator, the shift and the saturate/truncate logic. It takes first/last strobes from the shared counter.
- The top level owns the counter, config shadow, output register, handshake and overflow flag.

## Test plan
- Pick, D=4, ready_i=1, ch0 ramp 0,1,2,...: valid_o one cycle after samples 0,4,8; data_o ch0 = 0,4,8.
- Accumulate, D=4, shift=2, ch0 constant 12, ch1 constant -8: each output ch0=12, ch1=-8, one per 4 valid beats.
- Accumulate, D=4, shift=0, ch0 constant 100, DATA_BW=8:
  - with DECIMATOR_SAT_EN, data_o ch0 = 127;
  - without it, data_o ch0 = 400 mod 256 = 144, i.e. -112.
- Backpressure, pick, D=2, ready_i=0 for 6 beats: first result held stable; later results dropped; overflow_o=1 until en_i pulsed low.
- Mid-group disturbance, D=5, assert rst_i (then separately drop en_i) after 3 beats: no output from the partial group; the next group starts fresh at cnt=0.
- Change decim_i from 4 to 2 while en_i=1: rate stays 4. After an en_i low pulse: rate becomes 2.
